// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: program ROM address/data, fetch control and the
// valid/ready instruction stream toward decode.
interface instr_fetch_unit_if #(
    parameter int CNT_W = 3
) ();
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic             fetch_en;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr_data;
    logic [31:0]      instr_pc;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output imem_addr,
        input  imem_data,
        input  fetch_en,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output fifo_count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output fetch_en,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  fifo_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives the ROM address, queues {pc, word} in a prefetch
// FIFO and hands the head to decode over valid/ready; redirects flush and restart.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus_io
);
    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      data_mem_q [FIFO_DEPTH];
    logic [31:0]      pc_mem_q   [FIFO_DEPTH];

    logic full, valid, pop, push;

    assign full  = (count_q == FULL_CNT);
    assign valid = (count_q != '0);
    assign pop   = valid & bus_io.instr_ready;
    assign push  = bus_io.fetch_en & ~bus_io.redirect_valid & (~full | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus_io.redirect_valid) begin
            // Redirect wins over any push/pop on this edge.
            fetch_pc_d = {bus_io.redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: storage is not reset; an empty FIFO masks the head outputs to zero,
    // so stale entries are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= bus_io.imem_data;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign bus_io.imem_addr   = fetch_pc_q;
    assign bus_io.instr_valid = valid;
    assign bus_io.instr_data  = valid ? data_mem_q[rd_ptr_q] : 32'h0;
    assign bus_io.instr_pc    = valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
    assign bus_io.fifo_count  = count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_instr_fetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    entry_t      mq[$];
    logic [31:0] m_pc = 32'h0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.CNT_W(3)) if1 ();
    instr_fetch_unit_if #(.CNT_W(3)) if2 ();

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(4),
        .CNT_W     (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(if1)
    );

    instr_fetch_unit #(
        .RESET_PC  (32'hFFFF_FFF8),
        .FIFO_DEPTH(4),
        .CNT_W     (3)
    ) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus_io(if2)
    );

    // ROM contents: word index of the byte address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    assign if1.imem_data = rom(if1.imem_addr);
    assign if2.imem_data = rom(if2.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Reference model: a plain queue of {pc, word} plus the next fetch address.
    task automatic model_step();
        bit do_pop  = (mq.size() != 0) && if1.instr_ready;
        bit do_push = if1.fetch_en && !if1.redirect_valid && ((mq.size() < 4) || do_pop);
        if (if1.redirect_valid) begin
            mq.delete();
            m_pc <= {if1.redirect_pc[31:2], 2'b00};
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc: m_pc, data: rom(m_pc)});
                m_pc <= m_pc + 32'd4;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc <= 32'h0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        check("imem_addr", if1.imem_addr, m_pc);
        check("fifo_count", 32'(if1.fifo_count), 32'(mq.size()));
        check("instr_valid", 32'(if1.instr_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("instr_pc", if1.instr_pc, mq[0].pc);
            check("instr_data", if1.instr_data, mq[0].data);
        end
    end

    initial begin
        if1.fetch_en = 1'b1; if1.instr_ready = 1'b1;
        if1.redirect_valid = 1'b0; if1.redirect_pc = 32'h0;
        if2.fetch_en = 1'b1; if2.instr_ready = 1'b1;
        if2.redirect_valid = 1'b0; if2.redirect_pc = 32'h0;

        // Reset values, then one instruction per cycle from pc 0.
        cyc();
        check("rst_valid", 32'(if1.instr_valid), 32'h0);
        check("rst_data", if1.instr_data, 32'h0);
        check("rst_pc", if1.instr_pc, 32'h0);
        check("rst_count", 32'(if1.fifo_count), 32'h0);
        check("rst_addr", if1.imem_addr, 32'h0);
        rst_n = 1'b1;
        cyc();
        check("t1_valid", 32'(if1.instr_valid), 32'h1);
        check("t1_pc0", if1.instr_pc, 32'h0);
        check("t1_data0", if1.instr_data, 32'h0);
        cyc();
        check("t1_pc4", if1.instr_pc, 32'h4);
        check("t1_data1", if1.instr_data, 32'h1);
        cyc();
        check("t1_pc8", if1.instr_pc, 32'h8);

        // Stall decode: FIFO saturates, fetch address holds, head stable.
        rst_n = 1'b0; if1.instr_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc(10);
        check("t2_count_full", 32'(if1.fifo_count), 32'h4);
        check("t2_addr_hold", if1.imem_addr, 32'h10);
        check("t2_head_pc", if1.instr_pc, 32'h0);
        if1.instr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("t2_drain_pc", if1.instr_pc, 32'(4 * k));
        end
        check("t2_count_steady", 32'(if1.fifo_count), 32'h4);

        // Redirect while full; low address bits dropped.
        if1.redirect_valid = 1'b1; if1.redirect_pc = 32'h0000_0043;
        cyc();
        check("t3_valid", 32'(if1.instr_valid), 32'h0);
        check("t3_count", 32'(if1.fifo_count), 32'h0);
        check("t3_addr", if1.imem_addr, 32'h40);
        if1.redirect_valid = 1'b0;
        cyc();
        check("t3_head_pc", if1.instr_pc, 32'h40);
        check("t3_head_data", if1.instr_data, 32'h10);

        // Back-to-back redirects: last one wins.
        if1.redirect_valid = 1'b1; if1.redirect_pc = 32'h20;
        cyc();
        check("t4_valid_a", 32'(if1.instr_valid), 32'h0);
        if1.redirect_pc = 32'h80;
        cyc();
        check("t4_valid_b", 32'(if1.instr_valid), 32'h0);
        check("t4_addr", if1.imem_addr, 32'h80);
        if1.redirect_valid = 1'b0;
        cyc();
        check("t4_head_pc", if1.instr_pc, 32'h80);
        check("t4_head_data", if1.instr_data, 32'h20);

        // fetch_en low: queued entries drain, fetch address frozen.
        if1.instr_ready = 1'b0;
        cyc(2);
        check("t5_count3", 32'(if1.fifo_count), 32'h3);
        if1.fetch_en = 1'b0; if1.instr_ready = 1'b1;
        cyc(3);
        check("t5_valid", 32'(if1.instr_valid), 32'h0);
        check("t5_count0", 32'(if1.fifo_count), 32'h0);
        check("t5_addr", if1.imem_addr, 32'h8C);
        if1.fetch_en = 1'b1;

        // Randomized traffic; the model comparison runs every cycle.
        repeat (400) begin
            if1.fetch_en       = ($urandom_range(0, 3) != 0);
            if1.instr_ready    = ($urandom_range(0, 4) < 3);
            if1.redirect_valid = ($urandom_range(0, 19) == 0);
            if1.redirect_pc    = $urandom;
            cyc();
        end
        if1.redirect_valid = 1'b0; if1.fetch_en = 1'b1; if1.instr_ready = 1'b0;
        cyc(3);

        // Reset mid-stream with a non-empty queue: outputs clear at once.
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(if1.instr_valid), 32'h0);
        check("rst_mid_data", if1.instr_data, 32'h0);
        check("rst_mid_pc", if1.instr_pc, 32'h0);
        check("rst_mid_count", 32'(if1.fifo_count), 32'h0);
        check("rst_mid_addr", if1.imem_addr, 32'h0);
        cyc();
        rst_n = 1'b1; if1.instr_ready = 1'b1;
        cyc(3);

        // Address wrap from a high reset PC.
        rst2_n = 1'b1;
        cyc();
        check("t6_pc_fff8", if2.instr_pc, 32'hFFFF_FFF8);
        check("t6_data_fff8", if2.instr_data, 32'h3FFF_FFFE);
        cyc();
        check("t6_pc_fffc", if2.instr_pc, 32'hFFFF_FFFC);
        cyc();
        check("t6_pc_wrap", if2.instr_pc, 32'h0);
        check("t6_data_wrap", if2.instr_data, 32'h0);
        cyc();
        check("t6_pc_4", if2.instr_pc, 32'h4);
        #2 rst2_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(if2.instr_valid), 32'h0);
        check("t6_rst_data", if2.instr_data, 32'h0);
        check("t6_rst_pc", if2.instr_pc, 32'h0);
        check("t6_rst_count", 32'(if2.fifo_count), 32'h0);
        check("t6_rst_addr", if2.imem_addr, 32'hFFFF_FFF8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
